// File: rtl/kb_event_fifo.sv
// Keyboard/monitor event FIFO in the clk27 domain. The CPU pops the head by toggling an ack bit.
// It also reports the fill level, a sticky overflow flag and a saturating count of discarded events.
module kb_event_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int EDGE_TRIG = 1,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk27,
    input  logic                     reset_n,
    input  logic                     evt_valid,
    input  logic [DATA_W-1:0]        evt_data,
    input  logic                     rd_ack_tgl,
    input  logic                     cnt_clr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam bit OVW = (OVERWRITE != 0);
    localparam bit EDG = (EDGE_TRIG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              evt_prev_q, evt_prev_d;
    logic              ack_prev_q, ack_prev_d;

    logic              push_req, pop_req, pop_ok, drop, do_write, rd_adv;
    logic [LW-1:0]     remain;

    always_comb begin
        push_req   = EDG ? (evt_valid & ~evt_prev_q) : evt_valid;
        pop_req    = rd_ack_tgl ^ ack_prev_q;
        pop_ok     = pop_req & rd_valid_q;
        drop       = push_req & full_q & ~pop_ok;
        do_write   = push_req & (~full_q | pop_ok | OVW);
        // In overwrite mode a drop evicts the oldest entry, so the read side advances too.
        rd_adv     = pop_ok | (drop & OVW);

        wr_ptr_d   = wr_ptr_q + AW'(do_write);
        rd_ptr_d   = rd_ptr_q + AW'(rd_adv);
        level_d    = level_q + LW'(do_write) - LW'(rd_adv);
        remain     = level_q - LW'(rd_adv);
        rd_valid_d = (level_d != '0);
        full_d     = (level_d == LW'(DEPTH));

        // The head is registered. It bypasses the memory when the incoming word lands in an otherwise empty queue.
        rd_data_d  = rd_data_q;
        if (level_d != '0) begin
            if (remain == '0) begin
                rd_data_d = evt_data;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (cnt_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        evt_prev_d = evt_valid;
        ack_prev_d = rd_ack_tgl;
    end

    always_ff @(posedge clk27) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= evt_data;
        end
    end

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            evt_prev_q <= 1'b1;
            ack_prev_q <= rd_ack_tgl;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            evt_prev_q <= evt_prev_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
